// File: rtl/ps2_keyboard_rx.sv
// ps2_keyboard_rx: receive-only PS/2 host for keyboard port A.
// Synchronizes and deglitches the raw PS/2 clock/data pins, deframes 11-bit
// device-to-host frames (start, 8 data LSB first, odd parity, stop), and
// presents each good byte as a one-cycle strobe.
//
// Ports:
//   clk         in   system clock
//   rst         in   synchronous reset, active-high
//   sixus       in   1-cycle pulse every ~6us (timeout time base)
//   ps2_clk_raw in   raw PS/2 clock pin (asynchronous)
//   ps2_dat_raw in   raw PS/2 data pin (asynchronous)
//   rx_dat      out  last good byte, held until the next good byte
//   rx_stb      out  1-cycle pulse: rx_dat newly valid
//   rx_err      out  1-cycle pulse: frame dropped (parity/stop/timeout)
//   busy        out  high while a frame is in progress
module ps2_keyboard_rx #(
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned FILT_LEN      = 8,
    parameter int unsigned TIMEOUT_TICKS = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sixus,
    input  logic       ps2_clk_raw,
    input  logic       ps2_dat_raw,
    output logic [7:0] rx_dat,
    output logic       rx_stb,
    output logic       rx_err,
    output logic       busy
);

    localparam int unsigned FILT_W = $clog2(FILT_LEN + 1);
    localparam int unsigned TOUT_W = $clog2(TIMEOUT_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] clk_sync;
    logic [SYNC_STAGES-1:0] dat_sync;
    logic                   sclk;
    logic                   sdat;
    logic                   fclk;
    logic                   fclk_d;
    logic [FILT_W-1:0]      filt_cnt;
    logic                   fall;

    state_t                 state;
    logic [2:0]             bit_cnt;
    logic [7:0]             shreg;
    logic                   par_acc;
    logic                   par_ok;
    logic [TOUT_W-1:0]      tout_cnt;

    // Synchronizer chains; idle-high so reset looks like a quiet bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[SYNC_STAGES-2:0], ps2_clk_raw};
            dat_sync <= {dat_sync[SYNC_STAGES-2:0], ps2_dat_raw};
        end
    end

    assign sclk = clk_sync[SYNC_STAGES-1];
    assign sdat = dat_sync[SYNC_STAGES-1];

    // Glitch filter: accept a new clock level only after FILT_LEN steady cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            fclk     <= 1'b1;
            fclk_d   <= 1'b1;
            filt_cnt <= '0;
        end else begin
            fclk_d <= fclk;
            if (sclk == fclk) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FILT_W'(FILT_LEN - 1)) begin
                fclk     <= sclk;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FILT_W'(1);
            end
        end
    end

    assign fall = fclk_d & ~fclk;

    // Frame deserializer with timeout; a clock fall always beats a timeout tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_ok   <= 1'b0;
            tout_cnt <= '0;
            rx_dat   <= '0;
            rx_stb   <= 1'b0;
            rx_err   <= 1'b0;
            busy     <= 1'b0;
        end else begin
            rx_stb <= 1'b0;
            rx_err <= 1'b0;
            if (state == IDLE) begin
                tout_cnt <= '0;
                if (fall && !sdat) begin
                    state   <= DATA;
                    bit_cnt <= '0;
                    par_acc <= 1'b0;
                    busy    <= 1'b1;
                end
            end else if (fall) begin
                tout_cnt <= '0;
                case (state)
                    DATA: begin
                        shreg   <= {sdat, shreg[7:1]};
                        par_acc <= par_acc ^ sdat;
                        if (bit_cnt == 3'd7) begin
                            state <= PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    PARITY: begin
                        // Odd parity: data ones plus parity bit must be odd.
                        par_ok <= par_acc ^ sdat;
                        state  <= STOP;
                    end
                    STOP: begin
                        if (sdat && par_ok) begin
                            rx_dat <= shreg;
                            rx_stb <= 1'b1;
                        end else begin
                            rx_err <= 1'b1;
                        end
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end else if (sixus) begin
                if (tout_cnt == TOUT_W'(TIMEOUT_TICKS - 1)) begin
                    // Abort: drop the partial byte, leave rx_dat alone.
                    tout_cnt <= TOUT_W'(TIMEOUT_TICKS);
                    rx_err   <= 1'b1;
                    state    <= IDLE;
                    busy     <= 1'b0;
                end else begin
                    tout_cnt <= tout_cnt + TOUT_W'(1);
                end
            end
        end
    end

endmodule
